// File: rtl/fetch_pkg.sv
// Shared definitions for the PA2 instruction fetch sequencer: state encoding
// and instruction size.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE,
    ST_FAULT
  } fetch_state_e;

  localparam int INSTR_BYTES = 4;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Prefetch FIFO of {pc, instr}. Flush wins over push; a pop in the flush
// cycle still counts as consumed. Head outputs hold their last value when empty.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [31:0]       push_instr,
  input  logic              pop,
  input  logic              flush,
  output logic [ADDR_W-1:0] head_pc,
  output logic [31:0]       head_instr,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
);

  logic [ADDR_W-1:0] pc_mem_q  [DEPTH];
  logic [31:0]       ins_mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_left;
  logic [ADDR_W-1:0] head_pc_q, head_pc_d;
  logic [31:0]       head_instr_q, head_instr_d;
  logic              pop_ok, push_ok;

  assign empty      = (cnt_q == '0);
  assign full       = (cnt_q == CNT_W'(DEPTH));
  assign count      = cnt_q;
  assign head_pc    = head_pc_q;
  assign head_instr = head_instr_q;

  always_comb begin
    pop_ok       = pop && !empty;
    push_ok      = push && !flush && (!full || pop_ok);
    cnt_left     = cnt_q - CNT_W'(pop_ok);
    rd_ptr_d     = rd_ptr_q + PTR_W'(pop_ok);
    wr_ptr_d     = wr_ptr_q + PTR_W'(push_ok);
    cnt_d        = cnt_left + CNT_W'(push_ok);
    head_pc_d    = head_pc_q;
    head_instr_d = head_instr_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else if (cnt_left != '0) begin
      head_pc_d    = pc_mem_q[rd_ptr_d];
      head_instr_d = ins_mem_q[rd_ptr_d];
    end else if (push_ok) begin
      // Empty after the pop: the entry being written becomes the new head.
      head_pc_d    = push_pc;
      head_instr_d = push_instr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      head_pc_q    <= '0;
      head_instr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]  <= '0;
        ins_mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      head_pc_q    <= head_pc_d;
      head_instr_q <= head_instr_d;
      if (push_ok) begin
        pc_mem_q[wr_ptr_q]  <= push_pc;
        ins_mem_q[wr_ptr_q] <= push_instr;
      end
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// PA2 fetch sequencer: owns the PC, prefetches IM words into fetch_buf, and
// handles redirects and end-of-memory. FETCH_PERF_CNT_EN adds fetch/stall counters.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 128,
  parameter int RESET_PC  = 0,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [31:0]       instruction,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              busy,
  output logic              done,
  output logic              fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_count
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);
  localparam logic [ADDR_W-1:0] RST_PC    = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(INSTR_BYTES);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              busy_q, busy_d, done_q, done_d, fault_q, fault_d;
  logic              push, pop, flush, redir_ok;
  logic              buf_empty, buf_full;
  logic [CNT_W-1:0]  buf_count;

  assign instr_addr = pc_q;
  assign out_valid  = !buf_empty;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fault      = fault_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    push     = 1'b0;
    flush    = 1'b0;
    pop      = !buf_empty && out_ready;
    redir_ok = redirect_valid && (state_q == ST_FETCH || state_q == ST_DRAIN);
    if (redir_ok) begin
      flush = 1'b1;
      if (!is_aligned(redirect_pc[1:0])) begin
        state_d = ST_FAULT;
      end else if (redirect_pc < MEM_LIMIT) begin
        pc_d    = redirect_pc;
        state_d = ST_FETCH;
      end else begin
        state_d = ST_DRAIN;
      end
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d = ST_FETCH;
            pc_d    = RST_PC;
          end
        end
        ST_FETCH: begin
          if (pc_q >= MEM_LIMIT) begin
            state_d = ST_DRAIN;
          end else if (!buf_full || pop) begin
            push = 1'b1;
            pc_d = pc_q + STEP;
          end
        end
        ST_DRAIN: if (buf_count == '0) state_d = ST_DONE;
        ST_FAULT: ;
        default:  state_d = ST_IDLE;
      endcase
    end
    busy_d  = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
    done_d  = (state_d == ST_DONE);
    fault_d = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RST_PC;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  fetch_buf #(
    .ADDR_W (ADDR_W),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_pc    (pc_q),
    .push_instr (instruction),
    .pop        (pop),
    .flush      (flush),
    .head_pc    (out_pc),
    .head_instr (out_instr),
    .count      (buf_count),
    .empty      (buf_empty),
    .full       (buf_full)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d;
  logic        cnt_clr, stall;

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;

  always_comb begin
    cnt_clr     = start && (state_q == ST_IDLE || state_q == ST_DONE);
    // A stall is a FETCH cycle that wanted to push but found the buffer full.
    stall       = (state_q == ST_FETCH) && !redir_ok && (pc_q < MEM_LIMIT) && !push;
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr) begin
      fetch_cnt_d = '0;
      stall_cnt_d = '0;
    end else begin
      if (push && fetch_cnt_q != '1) fetch_cnt_d = fetch_cnt_q + 32'd1;
      if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
`endif

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the instruction memory for the PA2 CPU.
- Owns the PC and drives the IM address.
- Captures the combinational IM read data into a 2-entry prefetch buffer and hands {pc, instruction} to decode with a valid/ready handshake.
- Handles redirects (branch/jump), end-of-memory detection and misaligned-target faults.

Parameters:
- ADDR_W, 32, width of PC / IM address.
- MEM_BYTES, 128, IM size in bytes; fetch stops when PC >= MEM_BYTES.
- RESET_PC, 0, PC value after reset and on start.
- BUF_DEPTH, 2, prefetch buffer entries (power of 2, >= 2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins fetching from RESET_PC (honoured in IDLE and DONE only).
- instr_addr  out  ADDR_W  IM address; equals the PC register.
- instruction  in  32  IM read data, combinational from instr_addr.
- out_valid  out  1  buffer head valid.
- out_ready  in  1  decode accepts the head.
- out_instr  out  32  head instruction.
- out_pc  out  ADDR_W  head PC.
- redirect_valid  in  1  redirect request.
- redirect_pc  in  ADDR_W  redirect target.
- busy  out  1  state is FETCH or DRAIN.
- done  out  1  state is DONE.
- fault  out  1  state is FAULT.

Behaviour:
- Reset (async, any time, including mid-fetch):
  - State = IDLE, PC = RESET_PC, buffer empty.
  - out_valid = 0, out_instr = 0, out_pc = 0, busy = 0, done = 0, fault = 0.
- States and transitions:
  - IDLE: on start -> FETCH, PC = RESET_PC.
  - FETCH: push/advance rules below. When PC >= MEM_BYTES, no push -> DRAIN.
  - DRAIN: no pushes. When the buffer is empty -> DONE.
  - DONE: sticky. start -> FETCH with PC = RESET_PC.
  - FAULT: sticky until rst. Outputs hold; out_valid = 0.
- Push (FETCH only): push {PC, instruction} and PC += 4 when PC < MEM_BYTES and no redirect, and either:
  - count < BUF_DEPTH, or
  - count == BUF_DEPTH with a pop in the same cycle.
- Otherwise PC holds (stall).
- Pop: occurs when out_valid && out_ready. Simultaneous push and pop leaves count unchanged.
- Latency:
  - start sampled at edge N -> instr_addr = RESET_PC after N.
  - First out_valid after edge N+1.
  - Steady state: one instruction per cycle while out_ready = 1.
- Redirect (FETCH or DRAIN only; ignored in IDLE, DONE, FAULT):
  - Priority over push.
  - A pop in the same cycle completes (decode consumed it); all other entries are flushed.
  - redirect_pc[1:0] != 0 -> FAULT, buffer flushed.
  - Aligned and < MEM_BYTES -> PC = redirect_pc, state FETCH.
  - Aligned and >= MEM_BYTES -> buffer flushed, state DRAIN, then DONE next cycle.
- start while busy is ignored.
- PC arithmetic: ADDR_W-bit unsigned, wraps modulo 2^ADDR_W. A wrap cannot be reached because of the MEM_BYTES bound.
- Buffer entries update only on push; out_instr and out_pc hold their last value when empty.

Optional Feature:
- FETCH_PERF_CNT_EN defined: adds outputs fetch_count (32) and stall_count (32).
  - Both clear on rst and on start.
  - fetch_count increments per push.
  - stall_count increments per FETCH cycle with no push and no redirect (buffer full).
  - Both saturate at 0xFFFFFFFF.
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Package fetch_pkg: state encoding (IDLE, FETCH, DRAIN, DONE, FAULT) and the INSTR_BYTES = 4 constant.
- One sub-module, fetch_buf: BUF_DEPTH-entry FIFO of {pc, instr} with push, pop, flush, count, empty and full.
  - flush has priority over push.
  - pop is honoured in the same cycle as flush.

Test Plan:
- Reset then start, out_ready = 1, IM preloaded with 32 words 0x00000001..0x00000020 -> out_pc 0, 4, ... 124 on consecutive cycles with matching out_instr; first out_valid one cycle after FETCH entry; then DRAIN, done = 1, busy = 0.
- out_ready = 0 for 5 cycles after start -> exactly 2 entries buffered (pc 0, 4); instr_addr holds 8; stall_count = 3 when FETCH_PERF_CNT_EN; on release, pc 0, 4, 8 delivered in order with no gap.
- redirect_valid with redirect_pc = 0x40 while the buffer holds pc 8, 12 and out_ready = 1 -> pc 8 accepted, pc 12 flushed, next out_pc = 0x40.
- redirect_pc = 0x42 -> fault = 1 next cycle, out_valid = 0, start ignored; rst clears fault and returns to IDLE.
- redirect_pc = 0x80 -> buffer flushed, done = 1 within 2 cycles; start from DONE -> fetching resumes at pc 0.
- Assert rst mid-fetch at PC = 0x1C -> all outputs at reset values immediately (async), with no out_valid until the next start.
